// File: rtl/eth_params_pkg.sv
// Shared types for the UDP parameter loader: record layout, loader FSM states
// and the byte-sum helper used by the optional record checksum.
package eth_params_pkg;

  localparam int PARAM_BYTES = 26;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [47:0] src_mac;
    logic [31:0] dest_ip;
    logic [15:0] dest_port;
    logic [47:0] dest_mac;
    logic [7:0]  seed;
    logic [7:0]  generator;
  } udp_params_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    PENDING = 2'd2
  } loader_state_t;

  // Modulo-256 running sum step
  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/udp_param_loader.sv
// Assembles the UDP parameter record from UART bytes and commits it when the TX path is ready.
// Optional feature: define PARAM_CHECKSUM_EN to append and verify a trailing checksum byte.
module udp_param_loader
  import eth_params_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     tx_ready,
  output logic [8*PARAM_BYTES-1:0] params,
  output logic                     send,
  output logic                     busy,
  output logic                     err_timeout,
  output logic                     err_overrun,
  output logic                     err_checksum
);

`ifdef PARAM_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif
  localparam int REC_BYTES = PARAM_BYTES + CSUM_BYTES;
  localparam int IDX_W     = $clog2(REC_BYTES);
  localparam int TMR_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(REC_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

  loader_state_t            state_r;
  loader_state_t            state_nxt_s;
  logic [IDX_W-1:0]         idx_r;
  logic [TMR_W-1:0]         timer_r;
  logic [8*PARAM_BYTES-1:0] staging_r;
  udp_params_t              params_r;
  logic                     send_r;
  logic                     busy_r;
  logic                     err_timeout_r;
  logic                     err_overrun_r;

  logic                     last_s;
  logic                     accept_s;
  logic                     commit_s;
  logic                     timeout_s;
  logic                     overrun_s;
  logic                     csum_bad_s;
  logic                     store_en_s;
  int                       store_pos_s;

`ifdef PARAM_CHECKSUM_EN
  logic [7:0] sum_r;
  logic [7:0] sum_nxt_s;
  logic       err_checksum_r;
`endif

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    commit_s    = 1'b0;
    timeout_s   = 1'b0;
    overrun_s   = 1'b0;
    csum_bad_s  = 1'b0;
    last_s      = (idx_r == {IDX_W{1'b0}});
`ifdef PARAM_CHECKSUM_EN
    sum_nxt_s   = sum8(sum_r, rx_data);
`endif
    case (state_r)
      IDLE: begin
        if (rx_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = RECV;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RECV: begin
        // A byte arriving in the expiry cycle takes priority over the timeout
        if (rx_valid) begin
          accept_s = 1'b1;
          if (last_s) begin
`ifdef PARAM_CHECKSUM_EN
            csum_bad_s = (sum_nxt_s != 8'd0);
`else
            csum_bad_s = 1'b0;
`endif
            state_nxt_s = csum_bad_s ? IDLE : PENDING;
          end else begin
            state_nxt_s = RECV;
          end
        end else if (timer_r == TMR_LAST) begin
          timeout_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RECV;
        end
      end
      PENDING: begin
        if (tx_ready) begin
          commit_s    = 1'b1;
          accept_s    = rx_valid;
          state_nxt_s = rx_valid ? RECV : IDLE;
        end else begin
          overrun_s   = rx_valid;
          state_nxt_s = PENDING;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Where an accepted byte lands in the staging register
  always_comb begin
    store_en_s  = 1'b0;
    store_pos_s = 0;
`ifdef PARAM_CHECKSUM_EN
    store_en_s  = accept_s && !last_s;
    store_pos_s = int'(idx_r) - 1;
`else
    store_en_s  = accept_s;
    store_pos_s = int'(idx_r);
`endif
  end

  // State, staging, committed record and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      idx_r         <= IDX_TOP;
      timer_r       <= {TMR_W{1'b0}};
      staging_r     <= {(8*PARAM_BYTES){1'b0}};
      params_r      <= {(8*PARAM_BYTES){1'b0}};
      send_r        <= 1'b0;
      busy_r        <= 1'b0;
      err_timeout_r <= 1'b0;
      err_overrun_r <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
      sum_r          <= 8'd0;
      err_checksum_r <= 1'b0;
`endif
    end else begin
      state_r       <= state_nxt_s;
      send_r        <= commit_s;
      busy_r        <= (state_nxt_s != IDLE);
      err_timeout_r <= timeout_s;
      err_overrun_r <= overrun_s;

      if (commit_s) begin
        params_r <= udp_params_t'(staging_r);
      end
      if (store_en_s) begin
        staging_r[8*store_pos_s +: 8] <= rx_data;
      end else if (timeout_s) begin
        staging_r <= {(8*PARAM_BYTES){1'b0}};
      end

      // Timer only advances in RECV and saturates rather than wrapping
      if (accept_s) begin
        timer_r <= {TMR_W{1'b0}};
        idx_r   <= last_s ? IDX_TOP : idx_r - IDX_W'(1);
      end else if (timeout_s) begin
        timer_r <= {TMR_W{1'b0}};
        idx_r   <= IDX_TOP;
      end else if ((state_r == RECV) && (timer_r != TMR_MAX)) begin
        timer_r <= timer_r + TMR_W'(1);
      end

`ifdef PARAM_CHECKSUM_EN
      if (accept_s) begin
        sum_r <= last_s ? 8'd0 : sum_nxt_s;
      end else if (timeout_s) begin
        sum_r <= 8'd0;
      end
      err_checksum_r <= csum_bad_s;
      if (csum_bad_s) begin
        staging_r <= {(8*PARAM_BYTES){1'b0}};
      end
`endif
    end
  end

  assign params      = params_r;
  assign send        = send_r;
  assign busy        = busy_r;
  assign err_timeout = err_timeout_r;
  assign err_overrun = err_overrun_r;
`ifdef PARAM_CHECKSUM_EN
  assign err_checksum = err_checksum_r;
`else
  assign err_checksum = 1'b0;
`endif

endmodule

// File: tb/tb_udp_param_loader.sv
// Directed self-checking bench for udp_param_loader (short timeout for simulation).
// Honours PARAM_CHECKSUM_EN by appending checksum bytes and running the checksum cases.
module tb_udp_param_loader;
  import eth_params_pkg::*;

  localparam int T = 40;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic                     tx_ready;
  logic [8*PARAM_BYTES-1:0] params;
  logic                     send;
  logic                     busy;
  logic                     err_timeout;
  logic                     err_overrun;
  logic                     err_checksum;

  int n_checks = 0;
  int n_errs   = 0;
  int send_cnt = 0;
  int to_cnt   = 0;
  int ov_cnt   = 0;
  int cs_cnt   = 0;

  udp_param_loader #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_ready     (tx_ready),
    .params       (params),
    .send         (send),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun),
    .err_checksum (err_checksum)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (send)         send_cnt <= send_cnt + 1;
    if (err_timeout)  to_cnt   <= to_cnt + 1;
    if (err_overrun)  ov_cnt   <= ov_cnt + 1;
    if (err_checksum) cs_cnt   <= cs_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8*PARAM_BYTES-1:0] rec(input logic [7:0] start);
    logic [8*PARAM_BYTES-1:0] r;
    r = '0;
    for (int i = 0; i < PARAM_BYTES; i++) r[8*(PARAM_BYTES-1-i) +: 8] = start + 8'(i);
    return r;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Full record from 'start'; optional pause of T-1 idle cycles before byte pause_at,
  // first 'skip' bytes assumed already sent, corrupt flips the checksum
  task automatic send_record(input logic [7:0] start, input int pause_at, input bit corrupt, input int skip);
    logic [7:0] sum;
    logic [7:0] b;
    sum = 8'h00;
    for (int i = 0; i < PARAM_BYTES; i++) begin
      b   = start + 8'(i);
      sum = sum + b;
      if (i >= skip) begin
        if (i == pause_at) wait_cycles(T - 1);
        send_byte(b);
      end
    end
`ifdef PARAM_CHECKSUM_EN
    b = 8'h00 - sum;
    if (corrupt) b = b + 8'h01;
    send_byte(b);
`else
    if (corrupt) sum = 8'h00;
`endif
  endtask

  task automatic expect_commit(input string tag, input logic [8*PARAM_BYTES-1:0] exp);
    check({tag, "_send_pre"}, 256'(send), 256'(1'b0));
    wait_cycles(1);
    check({tag, "_send"}, 256'(send), 256'(1'b1));
    check({tag, "_params"}, 256'(params), 256'(exp));
    wait_cycles(1);
    check({tag, "_send_low"}, 256'(send), 256'(1'b0));
    check({tag, "_busy"}, 256'(busy), 256'(1'b0));
  endtask

  initial begin
    udp_params_t p;
    int sc;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    wait_cycles(3);
    check("rst_params", 256'(params), 256'(0));
    check("rst_send", 256'(send), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_errs", 256'({err_timeout, err_overrun, err_checksum}), 256'(0));
    reset = 1'b0;
    wait_cycles(2);

    // 1: basic record, commit two cycles after last byte
    send_record(8'h01, -1, 1'b0, 0);
    expect_commit("t1", rec(8'h01));
    p = udp_params_t'(params);
    check("t1_src_ip", 256'(p.src_ip), 256'(32'h01020304));
    check("t1_dest_mac", 256'(p.dest_mac), 256'(48'h131415161718));
    check("t1_seed", 256'(p.seed), 256'(8'h19));
    check("t1_generator", 256'(p.generator), 256'(8'h1A));
    check("t1_send_cnt", 256'(send_cnt), 256'(1));

    // 2: partial record then timeout
    for (int i = 0; i < 10; i++) send_byte(8'h50 + 8'(i));
    wait_cycles(T - 1);
    check("t2_busy_before", 256'(busy), 256'(1));
    check("t2_no_timeout_yet", 256'(to_cnt), 256'(0));
    wait_cycles(1);
    check("t2_err_timeout", 256'(err_timeout), 256'(1));
    check("t2_busy_after", 256'(busy), 256'(0));
    wait_cycles(1);
    check("t2_timeout_cnt", 256'(to_cnt), 256'(1));
    send_record(8'h21, -1, 1'b0, 0);
    expect_commit("t2", rec(8'h21));

    // 4: byte lands exactly on the expiry cycle
    send_record(8'h41, 5, 1'b0, 0);
    expect_commit("t4", rec(8'h41));
    check("t4_timeout_cnt", 256'(to_cnt), 256'(1));

    // 3: held record, overrun bytes dropped, commit on tx_ready
    tx_ready = 1'b0;
    sc = send_cnt;
    send_record(8'h61, -1, 1'b0, 0);
    wait_cycles(2);
    check("t3_busy", 256'(busy), 256'(1));
    for (int c = 0; c < 500; c++) begin
      if (c == 100 || c == 200 || c == 300) send_byte(8'hEE);
      else wait_cycles(1);
    end
    check("t3_overrun_cnt", 256'(ov_cnt), 256'(3));
    check("t3_no_send", 256'(send_cnt), 256'(sc));
    check("t3_params_held", 256'(params), 256'(rec(8'h41)));
    tx_ready = 1'b1;
    wait_cycles(1);
    check("t3_send", 256'(send), 256'(1));
    check("t3_params", 256'(params), 256'(rec(8'h61)));
    wait_cycles(1);
    check("t3_busy_after", 256'(busy), 256'(0));

    // Commit and first byte of the next record in the same cycle
    tx_ready = 1'b0;
    send_record(8'h71, -1, 1'b0, 0);
    wait_cycles(3);
    tx_ready = 1'b1;
    send_byte(8'h81);
    check("t3b_send", 256'(send), 256'(1));
    check("t3b_params", 256'(params), 256'(rec(8'h71)));
    check("t3b_busy", 256'(busy), 256'(1));
    send_record(8'h81, -1, 1'b0, 1);
    expect_commit("t3b", rec(8'h81));
    check("t3b_overrun_cnt", 256'(ov_cnt), 256'(3));

    // 5: reset in the middle of a record
    for (int i = 0; i < 13; i++) send_byte(8'hA1 + 8'(i));
    sc = send_cnt;
    reset = 1'b1;
    wait_cycles(2);
    check("t5_params", 256'(params), 256'(0));
    check("t5_busy", 256'(busy), 256'(0));
    reset = 1'b0;
    wait_cycles(2);
    check("t5_no_send", 256'(send_cnt), 256'(sc));
    send_record(8'hB1, -1, 1'b0, 0);
    expect_commit("t5", rec(8'hB1));

`ifdef PARAM_CHECKSUM_EN
    // 6: good and bad checksum
    send_record(8'h01, -1, 1'b0, 0);
    expect_commit("t6_good", rec(8'h01));
    sc = send_cnt;
    send_record(8'h01, -1, 1'b1, 0);
    wait_cycles(3);
    check("t6_cs_cnt", 256'(cs_cnt), 256'(1));
    check("t6_no_send", 256'(send_cnt), 256'(sc));
    check("t6_busy", 256'(busy), 256'(0));
`else
    check("t6_cs_tied", 256'(cs_cnt), 256'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
